// File: rtl/dm_byteen_mem.sv
// Byte-enable word memory for the M stage: lane-merged writes, 0/1/2-cycle reads, post-reset zero sweep.
// Read latency RD_LAT (0 = combinational); no backpressure: accesses are dropped while busy.
module dm_byteen_mem #(
    parameter int unsigned DEPTH          = 4096,
    parameter logic [31:0] BASE           = 32'h0,
    parameter int unsigned RD_LAT         = 0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic        m_data_re,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        rd_valid,
    output logic        busy,
    output logic        err,
    output logic        trace_we,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [31:0] trace_pc
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_READY;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dm_byteen_mem: DEPTH must be a power of two and at least 4");
    end

    logic [31:0] r_mem [DEPTH];

    state_t      r_state;
    logic [AW-1:0] r_cnt;
    logic        r_busy;
    logic        r_err;
    logic        r_trace_we;
    logic [31:0] r_trace_addr;
    logic [31:0] r_trace_data;
    logic [31:0] r_trace_pc;

    logic [31:0]   w_off;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_ready;
    logic          w_any_be;
    logic          w_wr;
    logic          w_rd;
    logic          w_oor;
    logic [31:0]   w_old;
    logic [31:0]   w_merged;
    logic          w_unused;

    // Address below BASE wraps to a huge offset, so both bounds are checked explicitly.
    assign w_off      = m_data_addr - BASE;
    assign w_in_range = (m_data_addr >= BASE) && (w_off[31:2] < 30'(DEPTH));
    assign w_idx      = w_off[AW+1:2];
    assign w_unused   = &{1'b0, w_off[1:0]};

    assign w_ready  = (r_state == S_READY);
    assign w_any_be = |m_data_byteen;
    assign w_wr     = w_ready && w_any_be && w_in_range;
    assign w_rd     = w_ready && m_data_re;
    assign w_oor    = w_ready && (m_data_re || w_any_be) && !w_in_range;

    assign w_old = r_mem[w_idx];

    always_comb begin
        w_merged = w_old;
        for (int b = 0; b < 4; b++) begin
            if (m_data_byteen[b]) begin
                w_merged[8*b +: 8] = m_data_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
            r_busy  <= CLEAR_ON_RESET;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_state <= S_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_READY;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep owns the write port until READY.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err        <= 1'b0;
            r_trace_we   <= 1'b0;
            r_trace_addr <= '0;
            r_trace_data <= '0;
            r_trace_pc   <= '0;
        end else begin
            r_err      <= w_oor;
            r_trace_we <= w_wr;
            if (w_wr) begin
                r_trace_addr <= {m_data_addr[31:2], 2'b00};
                r_trace_data <= w_merged;
                r_trace_pc   <= m_inst_addr;
            end
        end
    end

    if (RD_LAT == 0) begin : g_lat0
        assign m_data_rdata = (w_rd && w_in_range) ? w_old : '0;
        assign rd_valid     = w_rd;
    end else if (RD_LAT == 1) begin : g_lat1
        logic [31:0] r_rd_dat1;
        logic        r_rd_vld1;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_rd_dat1 <= '0;
                r_rd_vld1 <= 1'b0;
            end else begin
                r_rd_vld1 <= w_rd;
                r_rd_dat1 <= (w_rd && w_in_range) ? w_merged : '0;
            end
        end
        assign m_data_rdata = r_rd_dat1;
        assign rd_valid     = r_rd_vld1;
    end else if (RD_LAT == 2) begin : g_lat2
        logic [31:0] r_rd_dat1;
        logic [31:0] r_rd_dat2;
        logic        r_rd_vld1;
        logic        r_rd_vld2;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_rd_dat1 <= '0;
                r_rd_dat2 <= '0;
                r_rd_vld1 <= 1'b0;
                r_rd_vld2 <= 1'b0;
            end else begin
                r_rd_vld1 <= w_rd;
                r_rd_dat1 <= (w_rd && w_in_range) ? w_merged : '0;
                r_rd_vld2 <= r_rd_vld1;
                r_rd_dat2 <= r_rd_dat1;
            end
        end
        assign m_data_rdata = r_rd_dat2;
        assign rd_valid     = r_rd_vld2;
    end else begin : g_bad_lat
        $error("dm_byteen_mem: RD_LAT must be 0, 1 or 2");
    end

    assign busy       = r_busy;
    assign err        = r_err;
    assign trace_we   = r_trace_we;
    assign trace_addr = r_trace_addr;
    assign trace_data = r_trace_data;
    assign trace_pc   = r_trace_pc;

endmodule
